// File: rtl/game_pkg.sv
// game_pkg: shared constants and types for the enemy-plane field.
//   N_SLOTS/COORD_W   : slot count and coordinate width
//   HIT_W/HIT_H       : default hitbox half-extents (inclusive)
//   IDX_W             : width of a slot index
//   scan_state_t      : shot-resolution FSM encoding
//   sat_add8          : 8-bit saturating add used for the score
package game_pkg;

    localparam int N_SLOTS = 10;
    localparam int COORD_W = 8;
    localparam int HIT_W   = 4;
    localparam int HIT_H   = 4;
    localparam int IDX_W   = $clog2(N_SLOTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// hit_box_cmp: combinational hitbox test for one enemy slot.
//   ex, ey  : enemy coordinates
//   bx, by  : latched shooter coordinates
//   active  : slot holds a live plane
//   kill    : active and both |ex-bx| <= HIT_W and |ey-by| <= HIT_H
// Distances are larger-minus-smaller, so no wrap across 0 / max coordinate.
module hit_box_cmp #(
    parameter int COORD_W = 8,
    parameter int HIT_W   = 4,
    parameter int HIT_H   = 4
) (
    input  logic [COORD_W-1:0] ex,
    input  logic [COORD_W-1:0] ey,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic               active,
    output logic               kill
);

    localparam logic [COORD_W-1:0] LIM_X = COORD_W'(HIT_W);
    localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(HIT_H);

    logic [COORD_W-1:0] dx, dy;

    always_comb begin
        dx   = (ex >= bx) ? (ex - bx) : (bx - ex);
        dy   = (ey >= by) ? (ey - by) : (by - ey);
        kill = active && (dx <= LIM_X) && (dy <= LIM_Y);
    end

endmodule

// File: rtl/hit_scan_ctrl.sv
// hit_scan_ctrl: shot resolution sequencer for the enemy-plane field.
// A rising edge on fire (in IDLE) latches the shooter position and scans one
// slot per clock through a single hit_box_cmp. Kills accumulate in kill_mask;
// entering REPORT registers one-cycle des/load_x/hit/miss pulses and adds the
// kill count to a saturating score.
//   clock, resetn          : clock, async active-low reset
//   fire, self_x, self_y   : player fire level and shooter position
//   ex_flat, ey_flat       : packed enemy coordinates, slot i at [i*COORD_W +: COORD_W]
//   slot_active            : live-plane flags
//   busy                   : shot in progress
//   des, load_x            : per-slot kill pulses (identical timing)
//   hit, miss              : shot outcome pulses
//   score                  : saturating kill count
// Build option: MULTI_KILL_EN -- scan all slots and kill every overlap;
// otherwise the first kill in ascending slot order ends the scan.
module hit_scan_ctrl
    import game_pkg::*;
#(
    parameter int N_SLOTS = game_pkg::N_SLOTS,
    parameter int COORD_W = game_pkg::COORD_W,
    parameter int HIT_W   = game_pkg::HIT_W,
    parameter int HIT_H   = game_pkg::HIT_H
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       fire,
    input  logic [COORD_W-1:0]         self_x,
    input  logic [COORD_W-1:0]         self_y,
    input  logic [N_SLOTS*COORD_W-1:0] ex_flat,
    input  logic [N_SLOTS*COORD_W-1:0] ey_flat,
    input  logic [N_SLOTS-1:0]         slot_active,
    output logic                       busy,
    output logic [N_SLOTS-1:0]         des,
    output logic [N_SLOTS-1:0]         load_x,
    output logic                       hit,
    output logic                       miss,
    output logic [7:0]                 score
);

    localparam int IW = $clog2(N_SLOTS);

    scan_state_t        state;
    logic               fire_q;
    logic [COORD_W-1:0] bx, by;
    logic [IW-1:0]      idx;
    logic [N_SLOTS-1:0] kill_mask;

    logic [COORD_W-1:0] ex_cur, ey_cur;
    logic               kill;
    logic [N_SLOTS-1:0] mask_next;
    logic [7:0]         kill_cnt;
    logic               last_slot, scan_done;

    // Live (not latched) enemy coordinates for the slot under test.
    assign ex_cur = ex_flat[int'(idx)*COORD_W +: COORD_W];
    assign ey_cur = ey_flat[int'(idx)*COORD_W +: COORD_W];

    hit_box_cmp #(
        .COORD_W(COORD_W),
        .HIT_W  (HIT_W),
        .HIT_H  (HIT_H)
    ) u_cmp (
        .ex    (ex_cur),
        .ey    (ey_cur),
        .bx    (bx),
        .by    (by),
        .active(slot_active[idx]),
        .kill  (kill)
    );

    always_comb begin
        mask_next = kill_mask | (kill ? (N_SLOTS'(1) << idx) : '0);
        kill_cnt  = '0;
        for (int i = 0; i < N_SLOTS; i++)
            kill_cnt = kill_cnt + 8'(mask_next[i]);
        last_slot = (idx == IW'(N_SLOTS - 1));
`ifdef MULTI_KILL_EN
        scan_done = last_slot;
`else
        scan_done = last_slot | kill;
`endif
    end

    // Pulses are registered on the SCAN->REPORT edge so they are visible
    // during the REPORT cycle; REPORT clears them and returns to IDLE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            fire_q    <= 1'b0;
            bx        <= '0;
            by        <= '0;
            idx       <= '0;
            kill_mask <= '0;
            busy      <= 1'b0;
            des       <= '0;
            load_x    <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
        end else begin
            fire_q <= fire;
            des    <= '0;
            load_x <= '0;
            hit    <= 1'b0;
            miss   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire && !fire_q) begin
                        state     <= SCAN;
                        bx        <= self_x;
                        by        <= self_y;
                        idx       <= '0;
                        kill_mask <= '0;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    kill_mask <= mask_next;
                    if (scan_done) begin
                        state  <= REPORT;
                        des    <= mask_next;
                        load_x <= mask_next;
                        hit    <= |mask_next;
                        miss   <= ~|mask_next;
                        score  <= sat_add8(score, kill_cnt);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_scan_ctrl.sv
module tb_hit_scan_ctrl;

    localparam int N  = 10;
    localparam int CW = 8;

    logic            clock = 1'b0;
    logic            resetn;
    logic            fire;
    logic [CW-1:0]   self_x, self_y;
    logic [N*CW-1:0] ex_flat, ey_flat;
    logic [N-1:0]    slot_active;
    logic            busy, hit, miss;
    logic [N-1:0]    des, load_x;
    logic [7:0]      score;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    hit_scan_ctrl dut (
        .clock(clock), .resetn(resetn), .fire(fire),
        .self_x(self_x), .self_y(self_y),
        .ex_flat(ex_flat), .ey_flat(ey_flat), .slot_active(slot_active),
        .busy(busy), .des(des), .load_x(load_x),
        .hit(hit), .miss(miss), .score(score)
    );

    always #5 clock = ~clock;

    task automatic set_slot(input int i, input int x, input int y, input logic a);
        ex_flat[i*CW +: CW] = CW'(x);
        ey_flat[i*CW +: CW] = CW'(y);
        slot_active[i]      = a;
    endtask

    // All slots live but far from any shooter used below.
    task automatic set_far();
        for (int i = 0; i < N; i++) set_slot(i, 200, 10, 1'b1);
    endtask

    // Fires one shot and measures it; cycle numbers count from the edge that
    // samples the request (cycle c = value registered at edge c-1).
    task automatic run_shot(output logic [N-1:0] o_des, output logic [N-1:0] o_ldx,
                            output logic o_hit, output logic o_miss, output int o_cyc,
                            output logic o_busy1, output logic o_busy_end);
        o_des = '0; o_ldx = '0; o_hit = 0; o_miss = 0; o_cyc = -1;
        o_busy1 = 0; o_busy_end = 1;
        @(negedge clock);
        fire = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 1) o_busy1 = busy;
            if (hit || miss) begin
                o_des = des; o_ldx = load_x; o_hit = hit; o_miss = miss; o_cyc = c;
                break;
            end
        end
        @(negedge clock);
        o_busy_end = busy;
        fire = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0; fire = 1'b0;
        self_x = '0; self_y = '0;
        set_far();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (des !== '0 || load_x !== '0) begin errors++; $display("FAIL reset_des: got %0h/%0h want 0", des, load_x); end
        checks++; if (hit !== 1'b0 || miss !== 1'b0) begin errors++; $display("FAIL reset_hitmiss: got %0b%0b want 00", hit, miss); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    endtask

    task automatic test_single_kill();
        logic [N-1:0] d, l; logic h, m, b1, be; int cyc;
        int exp_cyc;
`ifdef MULTI_KILL_EN
        exp_cyc = 11;
`else
        exp_cyc = 5;
`endif
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        set_slot(3, 53, 96, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        exp_score = exp_score + 1;
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL kill_cycle: got %0d want %0d", cyc, exp_cyc); end
        checks++; if (d !== 10'b0000001000 || l !== 10'b0000001000) begin errors++; $display("FAIL kill_des: got %0h/%0h want 008", d, l); end
        checks++; if (h !== 1'b1 || m !== 1'b0) begin errors++; $display("FAIL kill_hit: got %0b%0b want 10", h, m); end
        checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL kill_score: got %0d want %0d", score, exp_score); end
        checks++; if (b1 !== 1'b1 || be !== 1'b0) begin errors++; $display("FAIL kill_busy: got %0b/%0b want 1/0", b1, be); end
    endtask

    task automatic test_reset_mid_scan();
        int pulses = 0;
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        set_slot(9, 50, 100, 1'b1);
        @(negedge clock);
        fire = 1'b1;
        @(posedge clock);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b want 0", busy); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL midreset_score: got %0d want 0", score); end
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            if (hit || miss || des != '0) pulses++;
        end
        fire = 1'b0;
        resetn = 1'b1;
        exp_score = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            if (hit || miss || des != '0 || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_miss_and_edges();
        logic [N-1:0] d, l; logic h, m, b1, be; int cyc;
        int kc3, kc0;
`ifdef MULTI_KILL_EN
        kc3 = 11; kc0 = 11;
`else
        kc3 = 5; kc0 = 2;
`endif
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        set_slot(3, 53, 96, 1'b0);
        run_shot(d, l, h, m, cyc, b1, be);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL miss_cycle: got %0d want 11", cyc); end
        checks++; if (m !== 1'b1 || h !== 1'b0 || d !== '0) begin errors++; $display("FAIL miss_pulse: got m%0b h%0b des %0h want m1 h0 des 0", m, h, d); end
        checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL miss_score: got %0d want %0d", score, exp_score); end
        // Inclusive corner of the box.
        set_slot(3, 54, 104, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        exp_score = exp_score + 1;
        checks++; if (d !== 10'h008 || cyc !== kc3) begin errors++; $display("FAIL edge_in: got des %0h cyc %0d want 008 cyc %0d", d, cyc, kc3); end
        // One past the x edge.
        set_slot(3, 55, 100, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        checks++; if (m !== 1'b1 || d !== '0) begin errors++; $display("FAIL edge_out: got m%0b des %0h want m1 des 0", m, d); end
        // Extremes of the coordinate range, no wrap.
        set_far();
        self_x = 8'd2; self_y = 8'd253;
        set_slot(0, 0, 255, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        exp_score = exp_score + 1;
        checks++; if (d !== 10'h001 || cyc !== kc0) begin errors++; $display("FAIL extreme: got des %0h cyc %0d want 001 cyc %0d", d, cyc, kc0); end
        checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL edge_score: got %0d want %0d", score, exp_score); end
    endtask

    task automatic test_two_overlap();
        logic [N-1:0] d, l; logic h, m, b1, be; int cyc;
        logic [N-1:0] exp_d; int exp_cyc, add;
`ifdef MULTI_KILL_EN
        exp_d = 10'h084; exp_cyc = 11; add = 2;
`else
        exp_d = 10'h004; exp_cyc = 4; add = 1;
`endif
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        set_slot(2, 48, 98, 1'b1);
        set_slot(7, 52, 103, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        exp_score = exp_score + add;
        checks++; if (d !== exp_d || l !== exp_d) begin errors++; $display("FAIL two_des: got %0h/%0h want %0h", d, l, exp_d); end
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL two_cycle: got %0d want %0d", cyc, exp_cyc); end
        checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL two_score: got %0d want %0d", score, exp_score); end
    endtask

    task automatic test_held_fire();
        int reports = 0;
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        @(negedge clock);
        fire = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (hit || miss) reports++;
        end
        fire = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (reports !== 1) begin errors++; $display("FAIL held_fire: got %0d reports want 1", reports); end
        reports = 0;
        fire = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (c == 2) fire = 1'b0;
            if (c == 4) fire = 1'b1;
            if (hit || miss) reports++;
        end
        fire = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (reports !== 1) begin errors++; $display("FAIL busy_press: got %0d reports want 1", reports); end
    endtask

    task automatic test_saturation();
        logic [N-1:0] d, l; logic h, m, b1, be; int cyc;
        set_far();
        self_x = 8'd50; self_y = 8'd100;
        set_slot(0, 50, 100, 1'b1);
        while (exp_score < 254) begin
            run_shot(d, l, h, m, cyc, b1, be);
            exp_score = exp_score + 1;
        end
        checks++; if (score !== 8'd254) begin errors++; $display("FAIL preset_score: got %0d want 254", score); end
        set_far();
        set_slot(2, 48, 98, 1'b1);
        set_slot(7, 52, 103, 1'b1);
        run_shot(d, l, h, m, cyc, b1, be);
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_first: got %0d want 255", score); end
        run_shot(d, l, h, m, cyc, b1, be);
        checks++; if (score !== 8'd255 || h !== 1'b1) begin errors++; $display("FAIL sat_hold: got %0d hit %0b want 255 hit 1", score, h); end
    endtask

    initial begin
        test_reset();
        test_single_kill();
        test_reset_mid_scan();
        test_miss_and_edges();
        test_two_overlap();
        test_held_fire();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
